// File: rtl/line_err_gen.sv
// ---------------------------------------------------------------------------
// line_err_gen
//
// Periodic IR line-sensor sweep controller. Once every PERIOD clocks it
// enables the IR emitters, waits SETTLE clocks for the receivers to settle,
// then converts the eight sensor channels in order through an external A2D.
// Each result is weighted by its lateral position (-8 .. +8) and summed into
// a signed accumulator. After the last channel the saturated sum is published
// as a 16-bit signed line-position error.
//
// Ports
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   en         in   1   sweep enable; low returns the block to IDLE
//   cnv_cmplt  in   1   A2D conversion-done pulse
//   res        in  12   A2D result (unsigned), valid with cnv_cmplt
//   IR_en      out  1   IR emitter enable
//   strt_cnv   out  1   one-cycle A2D conversion request
//   chnnl      out  3   A2D channel select
//   error      out 16   signed line-position error, held between updates
//   err_vld    out  1   one-cycle pulse, error updated on the same edge
//   flt        out  1   one-cycle pulse, conversion timed out
// ---------------------------------------------------------------------------
module line_err_gen #(
    parameter int unsigned PERIOD = 4096,
    parameter int unsigned SETTLE = 1024,
    parameter int unsigned TMO    = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        cnv_cmplt,
    input  logic [11:0] res,
    output logic        IR_en,
    output logic        strt_cnv,
    output logic [2:0]  chnnl,
    output logic [15:0] error,
    output logic        err_vld,
    output logic        flt
);

    localparam int unsigned PER_W = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam int unsigned SET_W = (SETTLE > 2) ? $clog2(SETTLE) : 1;
    localparam int unsigned TMO_W = (TMO > 2)    ? $clog2(TMO)    : 1;
    localparam int unsigned ACC_W = 17;
    localparam int unsigned ERR_W = 16;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PER    = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_REQ    = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]       state_q,   state_d;
    logic [PER_W-1:0] per_cnt_q, per_cnt_d;
    logic [SET_W-1:0] set_cnt_q, set_cnt_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [2:0]       ch_idx_q,  ch_idx_d;
    logic [ACC_W-1:0] acc_q,     acc_d;
    logic [ERR_W-1:0] error_q,   error_d;
    logic             ir_en_q,   ir_en_d;
    logic             strt_q,    strt_d;
    logic             err_vld_q, err_vld_d;
    logic             flt_q,     flt_d;

    logic             per_wrap;
    logic             set_done;
    logic             tmo_done;
    logic [1:0]       shamt;
    logic [ACC_W-1:0] res_weighted;
    logic [ACC_W-1:0] acc_next;
    logic [ERR_W-1:0] acc_sat;

    // Period counter wraps on its last count; only PER acts on the wrap.
    assign per_wrap = (per_cnt_q == PER_W'(PERIOD - 1));
    assign set_done = (set_cnt_q == SET_W'(SETTLE - 1));
    assign tmo_done = (tmo_cnt_q == TMO_W'(TMO - 1));

    // Position weight as a shift: ch0..3 -> 8,4,2,1 (subtract), ch4..7 -> 1,2,4,8 (add).
    assign shamt        = ch_idx_q[2] ? ch_idx_q[1:0] : ~ch_idx_q[1:0];
    assign res_weighted = {5'b0, res} << shamt;
    assign acc_next     = ch_idx_q[2] ? (acc_q + res_weighted) : (acc_q - res_weighted);

    // Clamp the 17-bit signed sum into 16 bits; bits [16:15] disagree only on overflow.
    always_comb begin
        acc_sat = acc_q[ERR_W-1:0];
        case (acc_q[ACC_W-1:ACC_W-2])
            2'b01:   acc_sat = 16'h7FFF;
            2'b10:   acc_sat = 16'h8000;
            default: acc_sat = acc_q[ERR_W-1:0];
        endcase
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        per_cnt_d = per_cnt_q;
        set_cnt_d = set_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        ch_idx_d  = ch_idx_q;
        acc_d     = acc_q;
        error_d   = error_q;
        err_vld_d = 1'b0;
        flt_d     = 1'b0;

        // Free-running sweep period; keeps the sweep grid fixed regardless of sweep outcome.
        if (state_q != S_IDLE) begin
            per_cnt_d = per_wrap ? '0 : (per_cnt_q + PER_W'(1));
        end

        if (!en) begin
            // Disable overrides everything; any partial sweep is discarded.
            state_d   = S_IDLE;
            per_cnt_d = '0;
            set_cnt_d = '0;
            tmo_cnt_d = '0;
            ch_idx_d  = '0;
            acc_d     = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    per_cnt_d = '0;
                    set_cnt_d = '0;
                    tmo_cnt_d = '0;
                    ch_idx_d  = '0;
                    acc_d     = '0;
                    state_d   = S_PER;
                end

                S_PER: begin
                    if (per_wrap) begin
                        acc_d     = '0;
                        ch_idx_d  = '0;
                        set_cnt_d = '0;
                        state_d   = S_SETTLE;
                    end
                end

                S_SETTLE: begin
                    if (set_done) begin
                        state_d = S_REQ;
                    end else begin
                        set_cnt_d = set_cnt_q + SET_W'(1);
                    end
                end

                S_REQ: begin
                    tmo_cnt_d = '0;
                    state_d   = S_WAIT;
                end

                S_WAIT: begin
                    // A completion on the timeout edge still counts as a completion.
                    if (cnv_cmplt) begin
                        acc_d = acc_next;
                        if (ch_idx_q == 3'd7) begin
                            state_d = S_DONE;
                        end else begin
                            ch_idx_d = ch_idx_q + 3'd1;
                            state_d  = S_REQ;
                        end
                    end else if (tmo_done) begin
                        flt_d   = 1'b1;
                        state_d = S_PER;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                    end
                end

                S_DONE: begin
                    error_d   = acc_sat;
                    err_vld_d = 1'b1;
                    state_d   = S_PER;
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Emitters lit only while a sweep is actively converting.
        ir_en_d = (state_d == S_SETTLE) || (state_d == S_REQ) || (state_d == S_WAIT);
        strt_d  = (state_d == S_REQ);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            per_cnt_q <= '0;
            set_cnt_q <= '0;
            tmo_cnt_q <= '0;
            ch_idx_q  <= '0;
            acc_q     <= '0;
            error_q   <= '0;
            ir_en_q   <= 1'b0;
            strt_q    <= 1'b0;
            err_vld_q <= 1'b0;
            flt_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            per_cnt_q <= per_cnt_d;
            set_cnt_q <= set_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            ch_idx_q  <= ch_idx_d;
            acc_q     <= acc_d;
            error_q   <= error_d;
            ir_en_q   <= ir_en_d;
            strt_q    <= strt_d;
            err_vld_q <= err_vld_d;
            flt_q     <= flt_d;
        end
    end

    // Channel index register doubles as the channel select; it changes only
    // when the current channel's completion is taken or a new sweep begins.
    assign IR_en    = ir_en_q;
    assign strt_cnv = strt_q;
    assign chnnl    = ch_idx_q;
    assign error    = error_q;
    assign err_vld  = err_vld_q;
    assign flt      = flt_q;

endmodule
